// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display back end: FSM states,
// the displayed snapshot layout, the blank code, the seven-segment glyph
// table and the digit positions of each field.
package score_disp_pkg;

    typedef enum logic [1:0] {IDLE, CONV_E, CONV_B, COMMIT} state_t;

    typedef struct packed {
        logic [7:0] fall_num;
        logic [7:0] eggs;
        logic [7:0] broken;
    } snap_t;

    // Blank code, only meaningful inside the BCD fields.
    localparam logic [3:0] BLANK = 4'hF;

    // Lowest digit index of each field (eggs 7..5, broken 4..2, fall_num 1..0).
    localparam int EGGS_LO   = 5;
    localparam int BROKEN_LO = 2;
    localparam int FALL_LO   = 0;

    // Active-low g..a glyphs for hex 0..F; entry 15 is listed first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    // Replace leading zeros of a 3-digit BCD value by BLANK; ones digit kept.
    function automatic logic [11:0] blank_lz(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[11:8] == 4'd0) begin
            r[11:8] = BLANK;
            if (v[7:4] == 4'd0) begin
                r[7:4] = BLANK;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one
// iteration per cycle. start accepted at edge k gives a one-cycle done
// after edge k+9; start is ignored while a conversion is running.
module bin2bcd_seq (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);
    logic [19:0] shift_reg;
    logic [19:0] shift_next;
    logic [11:0] adj;
    logic [3:0]  cnt_reg;
    logic        running_reg;
    logic        done_reg;

    // Add 3 to every BCD nibble that is 5 or more before the shift.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_adj
            always_comb begin
                adj[4*gi +: 4] = shift_reg[8 + 4*gi +: 4];
                if (shift_reg[8 + 4*gi +: 4] >= 4'd5) begin
                    adj[4*gi +: 4] = shift_reg[8 + 4*gi +: 4] + 4'd3;
                end
            end
        end
    endgenerate

    // One double-dabble step: adjusted digits and remaining binary shift left.
    always_comb begin
        shift_next = {adj[10:0], shift_reg[7:0], 1'b0};
    end

    // Load on start, iterate 8 times, then flag done for one cycle.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (!running_reg) begin
                if (start) begin
                    shift_reg   <= {12'd0, bin};
                    cnt_reg     <= 4'd8;
                    running_reg <= 1'b1;
                end
            end else if (cnt_reg != 4'd0) begin
                shift_reg <= shift_next;
                cnt_reg   <= cnt_reg - 4'd1;
            end else begin
                running_reg <= 1'b0;
                done_reg    <= 1'b1;
            end
        end
    end

    assign bcd  = shift_reg[19:8];
    assign done = done_reg;

endmodule

// File: rtl/score_display.sv
// 8-digit multiplexed seven-segment back end for the game counters.
// eggs and broken are shown in decimal (sequential conversion), fall_num
// in hex. A new snapshot is converted completely and committed to all
// digit registers in a single edge so the scan never shows a mix.
// Optional build macro SCORE_DISP_BLANK_LZ_EN blanks leading zeros of
// the decimal fields.
module score_display
    import score_disp_pkg::*;
#(
    parameter int DIV = 100000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] fall_num,
    input  logic [7:0] eggs,
    input  logic [7:0] broken,
    output logic [7:0] an,
    output logic [7:0] seg,
    output logic       busy
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t      state_reg, state_next;
    snap_t       in_q_reg, shown_reg, snap_reg;
    logic [11:0] eggs_bcd_reg, broken_bcd_reg;
    logic        issued_reg;
    logic [3:0]  d_reg    [8];
    logic [3:0]  commit_d [8];
    logic [11:0] eggs_disp, broken_disp;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [2:0]  idx_reg;
    logic [7:0]  an_reg, seg_reg, seg_next;
    logic [3:0]  cur_digit;
    logic        conv_start, conv_done;
    logic [7:0]  conv_bin;
    logic [11:0] conv_bcd;

    bin2bcd_seq u_conv (
        .clk_in (clk_in),
        .reset  (reset),
        .start  (conv_start),
        .bin    (conv_bin),
        .bcd    (conv_bcd),
        .done   (conv_done)
    );

    // FSM state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and converter request; start is issued once per field.
    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        conv_bin   = snap_reg.eggs;
        case (state_reg)
            IDLE:   if (in_q_reg != shown_reg) state_next = CONV_E;
            CONV_E: begin
                conv_start = !issued_reg;
                if (conv_done) state_next = CONV_B;
            end
            CONV_B: begin
                conv_start = !issued_reg;
                conv_bin   = snap_reg.broken;
                if (conv_done) state_next = COMMIT;
            end
            COMMIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Digit values written at COMMIT, with optional leading-zero blanking.
    always_comb begin
`ifdef SCORE_DISP_BLANK_LZ_EN
        eggs_disp   = blank_lz(eggs_bcd_reg);
        broken_disp = blank_lz(broken_bcd_reg);
`else
        eggs_disp   = eggs_bcd_reg;
        broken_disp = broken_bcd_reg;
`endif
        for (int i = 0; i < 3; i++) begin
            commit_d[EGGS_LO + i]   = eggs_disp[4*i +: 4];
            commit_d[BROKEN_LO + i] = broken_disp[4*i +: 4];
        end
        commit_d[FALL_LO]     = snap_reg.fall_num[3:0];
        commit_d[FALL_LO + 1] = snap_reg.fall_num[7:4];
    end

    // Input stage, snapshot capture, conversion results and shown snapshot.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            in_q_reg       <= '0;
            shown_reg      <= '0;
            snap_reg       <= '0;
            eggs_bcd_reg   <= '0;
            broken_bcd_reg <= '0;
            issued_reg     <= 1'b0;
        end else begin
            in_q_reg <= {fall_num, eggs, broken};
            if (conv_done) begin
                issued_reg <= 1'b0;
            end else if (conv_start) begin
                issued_reg <= 1'b1;
            end
            case (state_reg)
                IDLE:   if (in_q_reg != shown_reg) snap_reg <= in_q_reg;
                CONV_E: if (conv_done) eggs_bcd_reg <= conv_bcd;
                CONV_B: if (conv_done) broken_bcd_reg <= conv_bcd;
                COMMIT: shown_reg <= snap_reg;
                default: ;
            endcase
        end
    end

    // Digit registers, all loaded together at COMMIT.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            always_ff @(posedge clk_in or posedge reset) begin
                if (reset) begin
                    d_reg[gi] <= 4'd0;
                end else if (state_reg == COMMIT) begin
                    d_reg[gi] <= commit_d[gi];
                end
            end
        end
    endgenerate

    // Glyph for the current slot; blank code only honoured in BCD digits.
    always_comb begin
        cur_digit = d_reg[idx_reg];
        seg_next  = {1'b1, SEG_LUT[cur_digit]};
        if (idx_reg >= 3'(BROKEN_LO) && cur_digit == BLANK) begin
            seg_next = 8'hFF;
        end
    end

    // Slot timer, digit index and registered anode/cathode outputs.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            div_cnt_reg <= '0;
            idx_reg     <= 3'd0;
            an_reg      <= 8'hFF;
            seg_reg     <= 8'hFF;
        end else begin
            an_reg  <= ~(8'b1 << idx_reg);
            seg_reg <= seg_next;
            if (div_cnt_reg == DIV_LAST) begin
                div_cnt_reg <= '0;
                idx_reg     <= idx_reg + 3'd1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display (DIV=4) and the standalone
// bin2bcd_seq converter, with an arithmetic reference of the display.
module tb_score_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fall_num, eggs, broken;
    logic [7:0] an, seg;
    logic       busy;

    logic        c_start;
    logic [7:0]  c_bin;
    logic [11:0] c_bcd;
    logic        c_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    initial forever #5 clk = ~clk;

    score_display #(.DIV(4)) dut (
        .clk_in   (clk),
        .reset    (reset),
        .fall_num (fall_num),
        .eggs     (eggs),
        .broken   (broken),
        .an       (an),
        .seg      (seg),
        .busy     (busy)
    );

    bin2bcd_seq u_conv_tb (
        .clk_in (clk),
        .reset  (reset),
        .start  (c_start),
        .bin    (c_bin),
        .bcd    (c_bcd),
        .done   (c_done)
    );

    // Expected cathodes for a slot given the displayed values.
    function automatic logic [7:0] exp_seg(int slot, int f, int e, int b, bit blank);
        int v;
        bit bl;
        v  = 0;
        bl = 1'b0;
        case (slot)
            7: begin v = e / 100;        bl = (e < 100); end
            6: begin v = (e / 10) % 10;  bl = (e < 10);  end
            5: v = e % 10;
            4: begin v = b / 100;        bl = (b < 100); end
            3: begin v = (b / 10) % 10;  bl = (b < 10);  end
            2: v = b % 10;
            1: v = f / 16;
            default: v = f % 16;
        endcase
`ifndef SCORE_DISP_BLANK_LZ_EN
        bl = 1'b0;
`endif
        if (!blank) bl = 1'b0;
        return bl ? 8'hFF : glyph[v];
    endfunction

    task automatic apply(int f, int e, int b);
        @(negedge clk);
        fall_num = 8'(f);
        eggs     = 8'(e);
        broken   = 8'(b);
        $display("apply fall_num=%02h eggs=%0d broken=%0d", fall_num, eggs, broken);
    endtask

    // Align to the start of slot 0 and check one full scan round.
    task automatic check_scan(string name, int f, int e, int b, bit blank);
        logic [7:0] prev;
        logic [7:0] exp_an;
        logic [7:0] exp_s;
        int n;
        n = 0;
        prev = an;
        @(negedge clk);
        while (!(an == 8'hFE && prev != 8'hFE) && n < 80) begin
            prev = an;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL %s scan_sync: an=%02h never started slot 0", name, an);
            return;
        end
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 4; c++) begin
                exp_an = ~(8'b1 << s);
                exp_s  = exp_seg(s, f, e, b, blank);
                checks++;
                if (an !== exp_an || seg !== exp_s) begin
                    errors++;
                    $display("FAIL %s slot%0d: an=%02h seg=%02h expected an=%02h seg=%02h",
                             name, s, an, seg, exp_an, exp_s);
                end
                @(negedge clk);
            end
        end
        $display("scan %s checked", name);
    endtask

    // Exact scan from idx 0 right after reset release, showing all zeros.
    task automatic check_zero_sequence(string name, int cycles);
        logic [7:0] exp_an;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            exp_an = ~(8'b1 << ((c / 4) % 8));
            checks++;
            if (an !== exp_an || seg !== 8'hC0) begin
                errors++;
                $display("FAIL %s cycle%0d: an=%02h seg=%02h expected an=%02h seg=C0",
                         name, c, an, seg, exp_an);
            end
        end
    endtask

    task automatic wait_busy(bit level, int limit, output int n);
        n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fall_num = 8'd0; eggs = 8'd0; broken = 8'd0;
        c_start = 1'b0; c_bin = 8'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (an !== 8'hFF || seg !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: an=%02h seg=%02h busy=%b expected FF FF 0", an, seg, busy);
        end
        reset = 1'b0;
        check_zero_sequence("reset_scan", 64);
    endtask

    task automatic test_bin2bcd;
        int vals [4] = '{0, 99, 128, 255};
        logic [11:0] exp_bcd;
        bit exp_done;
        for (int i = 0; i < 4; i++) begin
            exp_bcd = {4'(vals[i] / 100), 4'((vals[i] / 10) % 10), 4'(vals[i] % 10)};
            @(negedge clk);
            c_bin = 8'(vals[i]);
            c_start = 1'b1;
            @(negedge clk);
            c_start = 1'b0;
            for (int j = 0; j <= 10; j++) begin
                exp_done = (j == 9);
                checks++;
                if (c_done !== exp_done) begin
                    errors++;
                    $display("FAIL conv_done bin=%0d k+%0d: done=%b expected %b", vals[i], j, c_done, exp_done);
                end
                if (j == 9) begin
                    checks++;
                    if (c_bcd !== exp_bcd) begin
                        errors++;
                        $display("FAIL conv_bcd bin=%0d: bcd=%03h expected %03h", vals[i], c_bcd, exp_bcd);
                    end
                end
                if (j == 4) begin
                    c_start = 1'b1;
                    c_bin = ~8'(vals[i]);
                end
                if (j == 5) c_start = 1'b0;
                @(negedge clk);
            end
            $display("convert bin=%0d bcd=%03h", vals[i], c_bcd);
        end
    endtask

    task automatic test_main;
        int n;
        apply(8'h3C, 255, 7);
        wait_busy(1'b1, 10, n);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL main_busy_rise: busy=%b expected 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || n > 24) begin
            errors++;
            $display("FAIL main_latency: busy=%b after %0d cycles expected 0 within 24", busy, n);
        end
        check_scan("main", 8'h3C, 255, 7, 1'b1);
    endtask

    task automatic test_random;
        int f, e, b;
        for (int i = 0; i < 5; i++) begin
            f = int'($urandom_range(0, 255));
            e = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (i == 0) e = 5;
            apply(f, e, b);
            repeat (40) @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL random_settle%0d: busy=%b expected 0", i, busy);
            end
            check_scan("random", f, e, b, 1'b1);
        end
    endtask

    task automatic test_mid_change;
        int n;
        int slot;
        logic [7:0] exp_s;
        apply(0, 0, 1);
        repeat (40) @(negedge clk);
        apply(0, 10, 1);
        wait_busy(1'b1, 10, n);
        repeat (14) @(negedge clk);
        eggs = 8'd20;
        $display("apply mid-conversion eggs=20");
        wait_busy(1'b0, 40, n);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_first_commit: busy=%b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reconvert: busy=%b expected 1", busy);
        end
        for (int c = 0; c < 20; c++) begin
            slot = -1;
            for (int s = 0; s < 8; s++) if (an === ~(8'b1 << s)) slot = s;
            exp_s = (slot >= 0) ? exp_seg(slot, 0, 10, 1, 1'b1) : 8'hXX;
            checks++;
            if (slot < 0 || seg !== exp_s) begin
                errors++;
                $display("FAIL mid_shows_10 cycle%0d: an=%02h seg=%02h expected seg=%02h", c, an, seg, exp_s);
            end
            @(negedge clk);
        end
        wait_busy(1'b0, 40, n);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_second_commit: busy=%b expected 0", busy);
        end
        check_scan("mid_final", 0, 20, 1, 1'b1);
    endtask

    task automatic test_reset_mid;
        int n;
        apply(8'hA5, 123, 45);
        wait_busy(1'b1, 10, n);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 8'hFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_async: an=%02h seg=%02h busy=%b expected FF FF 0", an, seg, busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_zero_sequence("reset_mid_scan", 20);
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_settle: busy=%b expected 0", busy);
        end
        check_scan("reset_mid_held", 8'hA5, 123, 45, 1'b1);
    endtask

    initial begin
        test_reset();
        test_bin2bcd();
        test_main();
        test_random();
        test_mid_change();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
